// File: rtl/datapath_pkg.sv
// Shared types for the parametrised single-bus datapath: bus source encoding,
// memory handshake states and the register-index width helper.
package datapath_pkg;

    typedef enum logic [3:0] {
        SRC_NONE   = 4'd0,
        SRC_GPR    = 4'd1,
        SRC_HI     = 4'd2,
        SRC_LO     = 4'd3,
        SRC_ZHI    = 4'd4,
        SRC_ZLO    = 4'd5,
        SRC_PC     = 4'd6,
        SRC_MDR    = 4'd7,
        SRC_INPORT = 4'd8,
        SRC_C      = 4'd9
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

    // A one-entry file still needs a one-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_register.sv
// Generic datapath register: asynchronous clear, synchronous load on enable.
module dp_register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath_gen.sv
// Single-bus datapath: encoded bus mux, GPR file, special registers and a
// registered memory handshake that tolerates wait-stated memory.
module datapath_gen
    import datapath_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_REGS   = 16,
    parameter int IMM_W      = 19,
    parameter int PC_STEP    = 1,
    parameter bit R0_BA_ZERO = 1'b1,
    localparam int IDX_W     = idx_w(NUM_REGS)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [3:0]         src_sel,
    input  logic [IDX_W-1:0]   gpr_rd_idx,
    input  logic               ba_out,
    input  logic               gpr_wr,
    input  logic [IDX_W-1:0]   gpr_wr_idx,
    input  logic               pc_in,
    input  logic               pc_inc,
    input  logic               ir_in,
    input  logic               y_in,
    input  logic               z_in,
    input  logic               hi_in,
    input  logic               lo_in,
    input  logic               mar_in,
    input  logic               mdr_in,
    input  logic               outport_in,
    input  logic [2*WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0]   inport_data,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               mem_busy,
    output logic               mem_done,
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [WIDTH-1:0]   ir_out,
    output logic [WIDTH-1:0]   outport_data
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q, y_q, hi_q, lo_q, mar_q, outport_q, zhi_q, zlo_q;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] gpr_q [NUM_REGS];
    logic [WIDTH-1:0] gpr_rd;
    logic signed [IMM_W-1:0] imm_s;
    logic signed [WIDTH-1:0] imm_ext;
    mem_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic             done_q, done_d;

    // pc_in outranks pc_inc; the increment wraps modulo 2^WIDTH.
    always_comb begin
        pc_d = pc_in ? bus : pc_q + WIDTH'(PC_STEP);
    end

    dp_register #(.WIDTH(WIDTH)) u_pc      (.clock(clock), .clear(clear), .en(pc_in | pc_inc), .d(pc_d), .q(pc_q));
    dp_register #(.WIDTH(WIDTH)) u_ir      (.clock(clock), .clear(clear), .en(ir_in),      .d(bus), .q(ir_q));
    dp_register #(.WIDTH(WIDTH)) u_y       (.clock(clock), .clear(clear), .en(y_in),       .d(bus), .q(y_q));
    dp_register #(.WIDTH(WIDTH)) u_hi      (.clock(clock), .clear(clear), .en(hi_in),      .d(bus), .q(hi_q));
    dp_register #(.WIDTH(WIDTH)) u_lo      (.clock(clock), .clear(clear), .en(lo_in),      .d(bus), .q(lo_q));
    dp_register #(.WIDTH(WIDTH)) u_mar     (.clock(clock), .clear(clear), .en(mar_in),     .d(bus), .q(mar_q));
    dp_register #(.WIDTH(WIDTH)) u_outport (.clock(clock), .clear(clear), .en(outport_in), .d(bus), .q(outport_q));
    dp_register #(.WIDTH(WIDTH)) u_zhi     (.clock(clock), .clear(clear), .en(z_in), .d(alu_result[2*WIDTH-1:WIDTH]), .q(zhi_q));
    dp_register #(.WIDTH(WIDTH)) u_zlo     (.clock(clock), .clear(clear), .en(z_in), .d(alu_result[WIDTH-1:0]),       .q(zlo_q));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_wr && (int'(gpr_wr_idx) < NUM_REGS)) begin
            gpr_q[gpr_wr_idx] <= bus;
        end
    end

    assign imm_s   = ir_q[IMM_W-1:0];
    assign imm_ext = WIDTH'(imm_s);

    always_comb begin
        gpr_rd = '0;
        if (int'(gpr_rd_idx) < NUM_REGS) begin
            gpr_rd = gpr_q[gpr_rd_idx];
        end
        // R0 used as a base address reads as zero.
        if (R0_BA_ZERO && ba_out && (gpr_rd_idx == '0)) begin
            gpr_rd = '0;
        end
        bus = '0;
        case (src_e'(src_sel))
            SRC_GPR:    bus = gpr_rd;
            SRC_HI:     bus = hi_q;
            SRC_LO:     bus = lo_q;
            SRC_ZHI:    bus = zhi_q;
            SRC_ZLO:    bus = zlo_q;
            SRC_PC:     bus = pc_q;
            SRC_MDR:    bus = mdr_q;
            SRC_INPORT: bus = inport_data;
            SRC_C:      bus = imm_ext;
            default:    bus = '0;
        endcase
    end

    // Memory handshake; MDR is frozen during REQ except for read-ack data.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        done_d  = 1'b0;
        mdr_d   = mdr_q;
        case (state_q)
            ST_IDLE: begin
                if (mdr_in) begin
                    mdr_d = bus;
                end
                if (mem_read || mem_write) begin
                    state_d = ST_REQ;
                    we_d    = ~mem_read;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            done_q  <= done_d;
            mdr_q   <= mdr_d;
        end
    end

    assign mem_req      = (state_q == ST_REQ);
    assign mem_busy     = (state_q == ST_REQ);
    assign mem_we       = (state_q == ST_REQ) && we_q;
    assign mem_done     = done_q;
    assign mem_addr     = mar_q;
    assign mem_wdata    = mdr_q;
    assign bus_out      = bus;
    assign y_out        = y_q;
    assign ir_out       = ir_q;
    assign outport_data = outport_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Scoreboard bench for datapath_gen: stimulus queues expectations, a negedge
// monitor compares them and checks every mem_done pulse against a done queue.
module tb_datapath_gen;
    import datapath_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [3:0]    src_sel = 4'd0;
    logic [3:0]    gpr_rd_idx = '0, gpr_wr_idx = '0;
    logic          ba_out = 0, gpr_wr = 0;
    logic          pc_in = 0, pc_inc = 0, ir_in = 0, y_in = 0, z_in = 0, hi_in = 0, lo_in = 0;
    logic          mar_in = 0, mdr_in = 0, outport_in = 0;
    logic [2*W-1:0] alu_result = '0;
    logic [W-1:0]  inport_data = '0, mem_rdata = '0;
    logic          mem_read = 0, mem_write = 0, mem_ack = 0;
    logic          mem_req, mem_we, mem_busy, mem_done;
    logic [W-1:0]  mem_addr, mem_wdata, bus_out, y_out, ir_out, outport_data;

    datapath_gen dut (
        .clock(clock), .clear(clear), .src_sel(src_sel), .gpr_rd_idx(gpr_rd_idx),
        .ba_out(ba_out), .gpr_wr(gpr_wr), .gpr_wr_idx(gpr_wr_idx),
        .pc_in(pc_in), .pc_inc(pc_inc), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .hi_in(hi_in), .lo_in(lo_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .outport_in(outport_in), .alu_result(alu_result), .inport_data(inport_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_done(mem_done), .bus_out(bus_out), .y_out(y_out),
        .ir_out(ir_out), .outport_data(outport_data)
    );

    always #5 clock = ~clock;

    localparam int O_BUS = 0, O_Y = 1, O_IR = 2, O_OUT = 3, O_ADDR = 4, O_WDATA = 5;
    localparam int O_REQ = 6, O_WE = 7, O_BUSY = 8, O_DONE = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [W-1:0] exp;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] done_q[$];
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] observe(input int sel);
        case (sel)
            O_BUS:   return bus_out;
            O_Y:     return y_out;
            O_IR:    return ir_out;
            O_OUT:   return outport_data;
            O_ADDR:  return mem_addr;
            O_WDATA: return mem_wdata;
            O_REQ:   return W'(mem_req);
            O_WE:    return W'(mem_we);
            O_BUSY:  return W'(mem_busy);
            default: return W'(mem_done);
        endcase
    endfunction

    // Monitor: drain expectations and check each completion pulse.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [W-1:0] got;
            e = exp_q.pop_front();
            got = observe(e.sel);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
            end
        end
        if (mem_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got mem_done=1 expected 0");
            end else begin
                logic [W-1:0] ew;
                ew = done_q.pop_front();
                if (mem_wdata !== ew) begin
                    errors++;
                    $display("FAIL done_mdr: got 0x%08h expected 0x%08h", mem_wdata, ew);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_now(input string name, input int sel, input logic [W-1:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = val;
        exp_q.push_back(e);
    endtask

    // Drive a value through INPORT onto the bus for one load edge.
    task automatic load_bus(input logic [W-1:0] val, input int which);
        src_sel = SRC_INPORT;
        inport_data = val;
        case (which)
            0: pc_in = 1;
            1: ir_in = 1;
            2: y_in = 1;
            3: hi_in = 1;
            4: mar_in = 1;
            5: mdr_in = 1;
            default: outport_in = 1;
        endcase
        tick();
        {pc_in, ir_in, y_in, hi_in, mar_in, mdr_in, outport_in} = '0;
        src_sel = SRC_NONE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        expect_now("rst_bus", O_BUS, 0);
        expect_now("rst_y", O_Y, 0);
        expect_now("rst_ir", O_IR, 0);
        expect_now("rst_req", O_REQ, 0);
        expect_now("rst_busy", O_BUSY, 0);
        expect_now("rst_done", O_DONE, 0);
        tick();
        clear = 0;
        tick();

        // Reset in the middle of a read
        load_bus(32'h10, 4);
        load_bus(32'h77, 2);
        load_bus(32'h99, 6);
        mem_read = 1;
        tick();
        mem_read = 0;
        expect_now("mid_req", O_REQ, 1);
        expect_now("mid_busy", O_BUSY, 1);
        expect_now("mid_addr", O_ADDR, 32'h10);
        expect_now("mid_y", O_Y, 32'h77);
        tick();
        clear = 1;
        src_sel = SRC_PC;
        expect_now("clr_req_async", O_REQ, 0);
        expect_now("clr_busy", O_BUSY, 0);
        expect_now("clr_addr", O_ADDR, 0);
        expect_now("clr_y", O_Y, 0);
        expect_now("clr_out", O_OUT, 0);
        expect_now("clr_bus", O_BUS, 0);
        tick();
        clear = 0;
        src_sel = SRC_NONE;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        expect_now("idle_after_clr", O_REQ, 0);
        tick();

        // GPR file and R0 base-address zeroing
        src_sel = SRC_INPORT;
        gpr_wr = 1;
        gpr_wr_idx = 0;
        inport_data = 32'h1234;
        tick();
        gpr_wr_idx = 5;
        inport_data = 32'hA5A5A5A5;
        tick();
        gpr_wr = 0;
        src_sel = SRC_GPR;
        gpr_rd_idx = 5;
        expect_now("gpr_r5", O_BUS, 32'hA5A5A5A5);
        tick();
        gpr_rd_idx = 0;
        ba_out = 1;
        expect_now("gpr_r0_ba", O_BUS, 0);
        tick();
        ba_out = 0;
        expect_now("gpr_r0", O_BUS, 32'h1234);
        tick();

        // Sign-extended immediate
        load_bus(32'h0007FFFF, 1);
        src_sel = SRC_C;
        expect_now("ir_out", O_IR, 32'h0007FFFF);
        expect_now("c_neg", O_BUS, 32'hFFFFFFFF);
        tick();
        load_bus(32'h0003FFFF, 1);
        src_sel = SRC_C;
        expect_now("c_pos", O_BUS, 32'h0003FFFF);
        tick();

        // PC wrap and pc_in priority
        load_bus(32'hFFFFFFFF, 0);
        src_sel = SRC_PC;
        expect_now("pc_load", O_BUS, 32'hFFFFFFFF);
        pc_inc = 1;
        tick();
        pc_inc = 0;
        expect_now("pc_wrap", O_BUS, 0);
        tick();
        src_sel = SRC_INPORT;
        inport_data = 32'h40;
        pc_in = 1;
        pc_inc = 1;
        tick();
        {pc_in, pc_inc} = '0;
        src_sel = SRC_PC;
        expect_now("pc_prio", O_BUS, 32'h40);
        tick();

        // Z, HI, LO sources
        alu_result = {32'h11112222, 32'h33334444};
        z_in = 1;
        tick();
        z_in = 0;
        src_sel = SRC_ZHI;
        expect_now("zhi", O_BUS, 32'h11112222);
        tick();
        src_sel = SRC_ZLO;
        expect_now("zlo", O_BUS, 32'h33334444);
        tick();
        src_sel = SRC_INPORT;
        inport_data = 32'hAB;
        lo_in = 1;
        tick();
        lo_in = 0;
        src_sel = SRC_LO;
        expect_now("lo", O_BUS, 32'hAB);
        tick();

        // Read with three wait states
        load_bus(32'h10, 4);
        mem_read = 1;
        tick();
        expect_now("rd_req", O_REQ, 1);
        expect_now("rd_we", O_WE, 0);
        expect_now("rd_addr", O_ADDR, 32'h10);
        tick();
        mem_read = 0;
        tick();
        tick();
        mem_ack = 1;
        mem_rdata = 32'hDEADBEEF;
        mdr_in = 1;
        src_sel = SRC_INPORT;
        inport_data = 32'h1111;
        done_q.push_back(32'hDEADBEEF);
        expect_now("rd_req_ack_cycle", O_REQ, 1);
        tick();
        {mem_ack, mdr_in} = '0;
        src_sel = SRC_MDR;
        expect_now("rd_req_low", O_REQ, 0);
        expect_now("rd_done", O_DONE, 1);
        expect_now("rd_mdr", O_BUS, 32'hDEADBEEF);
        tick();
        expect_now("rd_no_restart", O_REQ, 0);
        expect_now("rd_done_1cyc", O_DONE, 0);
        tick();

        // Write: MDR held while REQ is up
        load_bus(32'h55, 5);
        mem_write = 1;
        tick();
        mem_write = 0;
        src_sel = SRC_INPORT;
        inport_data = 32'h99;
        mdr_in = 1;
        expect_now("wr_req", O_REQ, 1);
        expect_now("wr_we", O_WE, 1);
        expect_now("wr_wdata", O_WDATA, 32'h55);
        tick();
        mdr_in = 0;
        expect_now("wr_wdata_held", O_WDATA, 32'h55);
        tick();
        mem_ack = 1;
        mem_rdata = 32'h00000BAD;
        done_q.push_back(32'h55);
        tick();
        mem_ack = 0;
        expect_now("wr_idle", O_REQ, 0);
        tick();

        // Read and write together resolve to a read; back-to-back request on done
        mem_read = 1;
        mem_write = 1;
        tick();
        {mem_read, mem_write} = '0;
        expect_now("both_we", O_WE, 0);
        expect_now("both_req", O_REQ, 1);
        mem_ack = 1;
        mem_rdata = 32'hCAFEF00D;
        done_q.push_back(32'hCAFEF00D);
        tick();
        mem_ack = 0;
        mem_write = 1;
        expect_now("b2b_done", O_DONE, 1);
        tick();
        mem_write = 0;
        expect_now("b2b_req", O_REQ, 1);
        expect_now("b2b_we", O_WE, 1);
        mem_ack = 1;
        done_q.push_back(32'hCAFEF00D);
        tick();
        mem_ack = 0;
        tick();
        tick();

        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing: got %0d pending expected 0", done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_gen.md
# datapath_gen

Parametrised successor to the single-bus datapath. It provides an encoded-select bus, a register file with indexed read/write, and the PC/IR/Y/Z/HI/LO/MAR/MDR/OUTPORT registers. A registered memory-handshake FSM replaces the combinational MDR read path, so the datapath works against wait-stated memory. It sits between the control unit (selects/enables in, IR out) and the external ALU (Y and bus out, result in) and memory.

## Interface
- WIDTH, 32: data width of the bus and every register.
- NUM_REGS, 16: number of general-purpose registers (GPRs), at least 2. Index width is $clog2(NUM_REGS).
- IMM_W, 19: width of the IR immediate field. Sign-extended to WIDTH to form source C.
- PC_STEP, 1: increment amount applied by pc_inc.
- R0_BA_ZERO, 1: when 1, reading R0 with ba_out set drives 0 onto the bus.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset.
- src_sel  in  4  encoded bus source (datapath_pkg::src_e): NONE, GPR, HI, LO, ZHI, ZLO, PC, MDR, INPORT, C.
- gpr_rd_idx  in  log2(NUM_REGS)  GPR driven onto the bus when src_sel=GPR.
- ba_out  in  1  base-address read qualifier for R0.
- gpr_wr  in  1  write the bus into GPR[gpr_wr_idx].
- gpr_wr_idx  in  log2(NUM_REGS)  GPR write index.
- pc_in, pc_inc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in  in  1 each  load enables.
- alu_result  in  2*WIDTH  loaded into Z ({ZHI,ZLO}) on z_in.
- inport_data  in  WIDTH  INPORT bus source.
- mem_read, mem_write  in  1  single-cycle transaction start pulses.
- mem_rdata  in  WIDTH; mem_ack  in  1  memory read data and completion strobe.
- mem_req, mem_we  out  1  registered request and write qualifier.
- mem_addr, mem_wdata  out  WIDTH  MAR and MDR contents.
- mem_busy, mem_done  out  1  transaction in flight; one-cycle completion pulse.
- bus_out, y_out, ir_out, outport_data  out  WIDTH  bus value and register contents.

## Operation
- Bus is a combinational mux on src_sel.
  - NONE drives 0.
  - C drives sign-extended IR[IMM_W-1:0].
  - GPR with R0_BA_ZERO=1, ba_out=1 and gpr_rd_idx=0 drives 0.
- Every register loads bus_out at the rising edge its enable is sampled high. Exceptions: Z loads alu_result; MDR has the special cases below.
- PC priority: pc_in over pc_inc. pc_inc gives PC <= PC+PC_STEP, mod 2^WIDTH, wraps silently.
- Memory FSM states:
  - IDLE: on mem_read or mem_write go to REQ. Latch we=mem_write, and mem_read wins if both are set.
  - REQ: mem_req=1 and mem_we=we. Wait for mem_ack, with no timeout. On ack go to IDLE and pulse mem_done for 1 cycle. On a read ack also load MDR <= mem_rdata.
- mem_read and mem_write are ignored while mem_busy is high (REQ).
- MDR while in REQ: mdr_in is ignored, so write data stays stable.
- MDR when mdr_in and a read ack coincide: the ack data wins.
- mem_addr and mem_wdata are the live MAR and MDR values; control must not load MAR during REQ.
- Reset (any time, including mid-transaction): all registers, GPRs and outputs go to 0, the FSM goes to IDLE, and mem_req drops asynchronously.

## Timing
- Bus: zero-latency combinational; sources are valid in the cycle their select is applied.
- Register load: the value is visible one cycle after the enable is sampled.
- Memory: mem_read sampled at edge k → mem_req high from k+1. Ack sampled at edge m → mem_req low, MDR updated and mem_done high, all in cycle m+1. Minimum latency is 2 cycles (ack in the first REQ cycle).
- A new request may be issued in the same cycle mem_done is high; it is sampled in IDLE.

## Structure
- datapath_pkg holds:
  - the src_e enum;
  - the memory FSM state enum (IDLE, REQ);
  - the derived index-width function.
- One sub-module, dp_register: a WIDTH-parametrised register with async clear and enable. It is instanced for PC, IR, Y, HI, LO, MAR, OUTPORT, ZHI and ZLO.
- The GPR file is an array inside datapath_gen.
- The FSM and MDR logic are inline.

## Test plan
- Reset mid-read: set clear in REQ → mem_req falls in the same cycle, all outputs read 0, and the FSM returns to IDLE.
- GPR/BA: write 0x1234 to R0 and 0xA5A5A5A5 to R5, then read back:
  - src=GPR, idx=5 → bus 0xA5A5A5A5;
  - idx=0, ba_out=1 → bus 0;
  - idx=0, ba_out=0 → bus 0x1234.
- C source: IR=0x0007FFFF with IMM_W=19 → bus 0xFFFFFFFF. IR=0x0003FFFF → bus 0x0003FFFF.
- PC wrap: PC=0xFFFFFFFF with pc_inc → 0x00000000. pc_in and pc_inc both set with bus 0x40 → PC=0x40.
- Read with 3 wait states: MAR=0x10, mem_read, ack on the 4th REQ cycle with rdata 0xDEADBEEF → MDR=0xDEADBEEF and a 1-cycle mem_done. A second mem_read during REQ is ignored, and mdr_in asserted on the ack cycle is overridden by the ack data.
- Write: MDR=0x55, mem_write → mem_we=1, mem_wdata=0x55 held until ack. mem_read and mem_write pulsed together → the transaction is a read (mem_we=0).
